// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, S-box, Rcon table and GF(2^8) helpers.
// Used by aes_key_expand; the optional key store is enabled with AES_KEY_STORE_EN.
package aes_pkg;
    localparam int AES128_ROUNDS = 10;
    typedef logic [15:0][7:0] key_t;
    typedef logic [3:0][7:0] word_t;
    typedef enum logic {IDLE, EMIT} ks_state_t;
    localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    // index 0 is the leftmost byte so the table reads in natural order
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic word_t sub_word(input word_t w);
        word_t r;
        for (int i = 0; i < 4; i++) r[i] = SBOX[w[i]];
        return r;
    endfunction
endpackage

// File: rtl/aes_key_word_next.sv
// aes_key_word_next: one AES-128 key schedule step (RotWord, SubWord, Rcon, word chain).
// Purely combinational.
module aes_key_word_next
    import aes_pkg::*;
(
    input  key_t        key,
    input  logic [7:0]  rcon,
    output key_t        key_next
);
    word_t t, w4, w5, w6, w7;
    assign t = sub_word({key[2], key[1], key[0], key[3]}) ^ {rcon, 24'h000000};
    assign w4 = key[15:12] ^ t;
    assign w5 = key[11:8] ^ w4;
    assign w6 = key[7:4] ^ w5;
    assign w7 = key[3:0] ^ w6;
    assign key_next = {w4, w5, w6, w7};
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule streaming round keys 0..NUM_ROUNDS with valid/ready.
// Optional AES_KEY_STORE_EN adds a store of emitted keys with a combinational read port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  key_t        key_in,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [3:0]  rk_index,
    output key_t        round_key,
    output logic        done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]  rd_index,
    output key_t        rd_key
`endif
);
    ks_state_t state, state_n;
    key_t key_n, key_adv;
    logic [3:0] idx_n;
    logic [7:0] rcon, rcon_n;
    logic done_n, accept, last;

    aes_key_word_next u_next (.key(round_key), .rcon(rcon), .key_next(key_adv));

    assign rk_valid = state == EMIT;
    assign busy = rk_valid;
    assign accept = rk_valid & rk_ready;
    assign last = rk_index == 4'(NUM_ROUNDS);

    always_comb begin
        state_n = state;
        key_n = round_key;
        idx_n = rk_index;
        rcon_n = rcon;
        done_n = 1'b0;
        if (state == IDLE && start) begin
            state_n = EMIT;
            key_n = key_in;
            idx_n = '0;
            rcon_n = RCON[0];
        end else if (accept && last) begin
            state_n = IDLE;
            done_n = 1'b1;
        end else if (accept) begin
            key_n = key_adv;
            idx_n = rk_index + 4'd1;
            rcon_n = xtime(rcon);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            round_key <= '0;
            rk_index <= '0;
            rcon <= RCON[0];
            done <= 1'b0;
        end else begin
            state <= state_n;
            round_key <= key_n;
            rk_index <= idx_n;
            rcon <= rcon_n;
            done <= done_n;
        end
    end

`ifdef AES_KEY_STORE_EN
    key_t store [NUM_ROUNDS+1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        end else if (accept) begin
            store[rk_index] <= round_key;
        end
    end
    assign rd_key = (rd_index <= 4'(NUM_ROUNDS)) ? store[rd_index] : '0;
`endif
endmodule
